gt_pack_telemetry: RTL

//  Framer for the telemetry serial link. Accepts 88-bit telemetry packets over a valid/ready handshake.

---
 rtl/gt_pack_telemetry_pkg.sv | 30 +++
 rtl/gt_pack_telemetry.sv | 138 +++++++++++++
 2 files changed

// File: rtl/gt_pack_telemetry_pkg.sv
// Shared telemetry-link framing constants: control/data bytes, idle word and per-word K masks.
// The framer and the matching unpacker both import this package.
package gt_pack_telemetry_pkg;

    localparam logic [7:0] K28_5     = 8'hBC;
    localparam logic [7:0] K27_7_SOP = 8'hFB;
    localparam logic [7:0] K29_7_EOP = 8'hFD;
    localparam logic [7:0] D16_2     = 8'h50;

    localparam logic [31:0] IDLE_WORD = {D16_2, K28_5, D16_2, K28_5};
    localparam logic [3:0]  IDLE_IS_K = 4'b0101;

    localparam int PKT_BYTES = 11;
    localparam int PKT_W     = PKT_BYTES * 8;

    localparam logic [3:0] W0_IS_K = 4'b0001;
    localparam logic [3:0] W1_IS_K = 4'b0000;
    localparam logic [3:0] W2_IS_K = 4'b0000;
    localparam logic [3:0] W3_IS_K = 4'b1100;

    // Encoding names the word currently on the GT data port.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOP,
        ST_BODY1,
        ST_BODY2,
        ST_EOP
    } tx_state_e;

endpackage

// File: rtl/gt_pack_telemetry.sv
// Telemetry link framer: packs 88-bit packets into 4-word K-flagged frames for the GT TX port,
// filling gaps with idle/comma words and forcing an idle after a bounded run of frame words.
module gt_pack_telemetry
    import gt_pack_telemetry_pkg::*;
#(
    parameter int IDLE_INTERVAL = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_enable,
    input  logic [PKT_W-1:0] pkt_data,
    input  logic             pkt_valid,
    output logic             pkt_ready,
    output logic [31:0]      gt_data,
    output logic [3:0]       gt_data_is_k,
    output logic [31:0]      frames_sent
);

    localparam int              RUN_W      = $clog2(IDLE_INTERVAL + 1);
    localparam logic [RUN_W-1:0] RUN_MAX    = '1;
    localparam logic [RUN_W-1:0] RUN_THRESH = RUN_W'(IDLE_INTERVAL - 4);

    tx_state_e        state_q, state_d;
    logic [PKT_W-1:0] hold_q, hold_d;
    logic [7:0]       seq_q, seq_d;
    logic [7:0]       frame_seq_q, frame_seq_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [31:0]      frames_q, frames_d;
    logic [31:0]      word_q, word_d;
    logic [3:0]       is_k_q, is_k_d;
    logic             idle_due;
    logic             accept;

    function automatic logic [7:0] frame_chk(input logic [7:0] seq, input logic [PKT_W-1:0] pkt);
        logic [7:0] c;
        c = seq;
        for (int i = 0; i < PKT_BYTES; i++) begin
            c = c ^ pkt[i*8 +: 8];
        end
        return c;
    endfunction

    // Decided at EOP so the frame already in flight always completes before the forced idle.
    assign idle_due  = (run_q >= RUN_THRESH);
    assign pkt_ready = rst_n & tx_enable & ~idle_due & ((state_q == ST_IDLE) | (state_q == ST_EOP));
    assign accept    = pkt_valid & pkt_ready;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        seq_d       = seq_q;
        frame_seq_d = frame_seq_q;
        frames_d    = frames_q;
        run_d       = run_q;
        word_d      = IDLE_WORD;
        is_k_d      = IDLE_IS_K;

        if (accept) begin
            hold_d = pkt_data;
        end

        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_SOP;
            ST_SOP: begin
                state_d = ST_BODY1;
                seq_d   = seq_q + 8'd1;
            end
            ST_BODY1: state_d = ST_BODY2;
            ST_BODY2: state_d = ST_EOP;
            ST_EOP: begin
                state_d  = accept ? ST_SOP : ST_IDLE;
                frames_d = frames_q + 32'd1;
            end
            default:  state_d = ST_IDLE;
        endcase

        if (state_d == ST_SOP) begin
            frame_seq_d = seq_q;
        end

        // Run length counts frame cycles preceding the current one; any idle word restarts it.
        if ((state_q == ST_IDLE) || (state_d == ST_IDLE)) begin
            run_d = '0;
        end else if (run_q != RUN_MAX) begin
            run_d = run_q + RUN_W'(1);
        end

        case (state_d)
            ST_SOP: begin
                word_d = {hold_d[79:72], hold_d[87:80], seq_q, K27_7_SOP};
                is_k_d = W0_IS_K;
            end
            ST_BODY1: begin
                word_d = {hold_q[47:40], hold_q[55:48], hold_q[63:56], hold_q[71:64]};
                is_k_d = W1_IS_K;
            end
            ST_BODY2: begin
                word_d = {hold_q[15:8], hold_q[23:16], hold_q[31:24], hold_q[39:32]};
                is_k_d = W2_IS_K;
            end
            ST_EOP: begin
                word_d = {K28_5, K29_7_EOP, frame_chk(frame_seq_q, hold_q), hold_q[7:0]};
                is_k_d = W3_IS_K;
            end
            default: begin
                word_d = IDLE_WORD;
                is_k_d = IDLE_IS_K;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            seq_q       <= '0;
            frame_seq_q <= '0;
            run_q       <= '0;
            frames_q    <= '0;
            word_q      <= IDLE_WORD;
            is_k_q      <= IDLE_IS_K;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            seq_q       <= seq_d;
            frame_seq_q <= frame_seq_d;
            run_q       <= run_d;
            frames_q    <= frames_d;
            word_q      <= word_d;
            is_k_q      <= is_k_d;
        end
    end

    assign gt_data      = word_q;
    assign gt_data_is_k = is_k_q;
    assign frames_sent  = frames_q;

endmodule
